// File: rtl/despread_pkg.sv
// Shared constants and types for the QPSK despreader.
// Optional metric output is enabled with QPSK_DESPREAD_METRIC_EN.
package despread_pkg;

  localparam int DEF_SPREAD = 24;
  localparam logic [23:0] PN_CODE = 24'h5A3C96;
  localparam int ACC_W = 16 + $clog2(DEF_SPREAD);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

endpackage

// File: rtl/despread_out_buf.sv
// Two-entry output FIFO; ready term lets a push ride a same-cycle pop.
// No configuration macros.
module despread_out_buf
  import despread_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready_out,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         ready
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         empty;
  logic         full;
  logic         pop;

  always_comb begin
    empty = (cnt == 2'd0);
    full  = (cnt == 2'd2);
    valid = !empty;
    pop   = valid && ready_out;
    ready = !full || pop;
    dout  = mem[rp];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop)
        rp <= ~rp;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/qpsk_despread.sv
// Chip-rate QPSK despreader: PN correlation, hard decision, byte packing.
// Define QPSK_DESPREAD_METRIC_EN to add o_metric/o_metric_valid.
module qpsk_despread
  import despread_pkg::*;
#(
  parameter int SPREAD          = DEF_SPREAD,
  parameter int SIZE_INPUT_BIT  = 32,
  parameter int SIZE_OUTPUT_BIT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [SIZE_INPUT_BIT-1:0]  i_data,
  input  logic                       i_valid,
  input  logic                       i_sof,
  output logic                       o_ready,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready_output
`ifdef QPSK_DESPREAD_METRIC_EN
  ,
  output logic [16+$clog2(SPREAD):0] o_metric,
  output logic                       o_metric_valid
`endif
);

  localparam int CW = $clog2(SPREAD);
  localparam int AW = 16 + CW;
  localparam logic [CW-1:0] LAST = CW'(SPREAD - 1);

  state_t                 state;
  logic [CW-1:0]          chip;
  logic [1:0]             sym;
  logic [5:0]             bits;
  logic signed [AW-1:0]   acc_i;
  logic signed [AW-1:0]   acc_q;

  logic                   accept;
  logic                   start;
  logic                   active;
  logic                   last;
  logic                   pn;
  logic                   push;
  logic [CW-1:0]          chip_cur;
  logic [CW-1:0]          pn_idx;
  logic [1:0]             sym_cur;
  logic [15:0]            d_i;
  logic [15:0]            d_q;
  logic signed [AW-1:0]   s_i;
  logic signed [AW-1:0]   s_q;
  logic signed [AW-1:0]   base_i;
  logic signed [AW-1:0]   base_q;
  logic signed [AW-1:0]   sum_i;
  logic signed [AW-1:0]   sum_q;
  logic [7:0]             byte_nxt;

  always_comb begin
    accept   = i_valid && o_ready;
    start    = accept && i_sof;
    active   = accept && (state == RUN || i_sof);
    chip_cur = start ? '0 : chip;
    sym_cur  = start ? 2'd0 : sym;
    pn_idx   = LAST - chip_cur;
    pn       = PN_CODE[pn_idx];
    last     = (chip_cur == LAST);
    d_i      = i_data[SIZE_INPUT_BIT-1 -: 16];
    d_q      = i_data[15:0];
    s_i      = {{(AW-16){d_i[15]}}, d_i};
    s_q      = {{(AW-16){d_q[15]}}, d_q};
    base_i   = start ? '0 : acc_i;
    base_q   = start ? '0 : acc_q;
    sum_i    = pn ? base_i - s_i : base_i + s_i;
    sum_q    = pn ? base_q - s_q : base_q + s_q;
    byte_nxt = {bits, sum_i[AW-1], sum_q[AW-1]};
    push     = active && last && (sym_cur == 2'd3);
  end

  // A realigning sof restarts chip/symbol counting from this sample.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= WAIT_SOF;
      chip  <= '0;
      sym   <= 2'd0;
      bits  <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (active) begin
      state <= RUN;
      if (last) begin
        chip  <= '0;
        sym   <= sym_cur + 2'd1;
        bits  <= {bits[3:0], sum_i[AW-1], sum_q[AW-1]};
        acc_i <= '0;
        acc_q <= '0;
      end else begin
        chip  <= chip_cur + 1'b1;
        sym   <= sym_cur;
        acc_i <= sum_i;
        acc_q <= sum_q;
      end
    end
  end

`ifdef QPSK_DESPREAD_METRIC_EN
  logic [AW-1:0] mag_i;
  logic [AW-1:0] mag_q;

  always_comb begin
    mag_i = sum_i[AW-1] ? -sum_i : sum_i;
    mag_q = sum_q[AW-1] ? -sum_q : sum_q;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_metric       <= '0;
      o_metric_valid <= 1'b0;
    end else begin
      o_metric_valid <= active && last;
      if (active && last)
        o_metric <= {1'b0, mag_i} + {1'b0, mag_q};
    end
  end
`endif

  despread_out_buf #(
    .W(SIZE_OUTPUT_BIT)
  ) u_buf (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .push      (push),
    .din       (byte_nxt),
    .ready_out (i_ready_output),
    .dout      (o_data),
    .valid     (o_valid),
    .ready     (o_ready)
  );

endmodule

// File: doc/qpsk_despread.md
# qpsk_despread

Receive-side counterpart of the transmit spreader/QPSK mapper. Takes chip-rate I/Q samples (after matched filtering and decimation), correlates each branch against the 24-chip PN code, makes a hard decision per branch per symbol, and repacks the recovered bits into bytes. It sits between the receive filter chain and byte-level deframing, and emits bytes on a valid/ready handshake.

## Interface
- SPREAD, 24: chips per symbol; equals PN code length.
- SIZE_INPUT_BIT, 32: sample word, I in [31:16], Q in [15:0], each signed two's complement.
- SIZE_OUTPUT_BIT, 8: output byte width.

- i_clk  in  1  sole clock; all logic rising-edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_data  in  SIZE_INPUT_BIT  one chip sample {I, Q}.
- i_valid  in  1  i_data valid.
- i_sof  in  1  qualified by i_valid && o_ready; marks the first chip of a symbol that starts a new byte.
- o_ready  out  1  block accepts a sample this cycle.
- o_data  out  SIZE_OUTPUT_BIT  recovered byte.
- o_valid  out  1  o_data valid.
- i_ready_output  in  1  downstream accepts o_data.

## Operation
- A sample is accepted when i_valid && o_ready.
- Chip j of a symbol (0..SPREAD-1) uses PN_CODE[SPREAD-1-j]; chip 0 is the MSB.
- For each branch, the accumulator adds the sample when the PN bit is 0 and subtracts it when the PN bit is 1.
- Accumulator width ACC_W = 16 + $clog2(SPREAD) = 21 bits, signed. Overflow is not possible.
- Decision: recovered bit = 1 when the final sum is < 0, otherwise 0.
- Each symbol yields two bits, I first then Q. Bits shift into the byte MSB-first, so 4 symbols make 1 byte.
- FSM states:
  - WAIT_SOF: accepted samples are discarded. An accepted sample with i_sof moves to RUN, and that sample is chip 0.
  - RUN: chip counter counts 0..SPREAD-1 and wraps to 0. After the last chip, the accumulators clear and the symbol counter advances 0..3. On wrap of the symbol counter, the byte is pushed to the output buffer.
  - An accepted i_sof while in RUN realigns: the partial symbol and partial byte are dropped, and the sample is treated as chip 0.
- Output buffer: 2-entry FIFO.
  - o_valid = FIFO not empty; o_data = FIFO head.
  - Pop on o_valid && i_ready_output.
  - o_ready = !(FIFO full) || pop this cycle. A completed byte is therefore never dropped.
- Simultaneous push and pop when the FIFO is full is legal; occupancy stays at 2.

## Timing
- Reset state:
  - FSM = WAIT_SOF; all counters and accumulators = 0; FIFO empty.
  - o_valid = 0, o_data = 0, o_ready = 1.
- Reset asserted mid-byte discards all partial state and buffered bytes; no spurious o_valid follows.
- Latency: the last chip of the 4th symbol is accepted in cycle t, and o_valid = 1 with the byte in cycle t+1, provided the FIFO was empty.
- Throughput: 1 chip per clock. Stalls occur only under output backpressure.
- o_data and o_valid stay stable while o_valid && !i_ready_output.

## Configuration
- QPSK_DESPREAD_METRIC_EN defined: adds two ports.
  - o_metric, 22 bits, out: |accI| + |accQ| of the last completed symbol, registered.
  - o_metric_valid, 1 bit, out: pulses for one cycle, in the cycle after each symbol's last chip.
  - Both are 0 at reset.
- Not defined: the ports and their logic are absent, and the remaining behaviour is identical.

## Structure
- Package despread_pkg holds:
  - SPREAD default and PN_CODE = 24'h5A3C96.
  - ACC_W.
  - FSM enum state_t {WAIT_SOF, RUN}.
- Sub-module despread_out_buf: the 2-entry FIFO with full/empty flags and the o_ready term. Everything else stays in qpsk_despread.

## Test plan
- Reset release with no input -> o_valid = 0, o_data = 8'h00, o_ready = 1. Samples without a prior i_sof produce no output.
- Byte 8'hC5, symbols (1,1), (0,0), (0,1), (0,1), sent as ±1000 chips with i_sof on chip 0 and 96 consecutive valid samples -> o_data = 8'hC5 with o_valid one cycle after chip 95. With the metric macro, o_metric = 48000 on each symbol.
- Three bytes 8'h01, 8'h80, 8'hFF back-to-back with i_ready_output = 0 -> o_ready drops once 2 bytes are buffered. After i_ready_output = 1, bytes emerge in order 01, 80, FF with none lost.
- All samples -32768 on I and Q, with PN chips applied so the sum is maximal -> accumulators reach -786432 with no wrap. Decoded byte = 8'hFF.
- i_sof reasserted at chip 10 of symbol 2 -> partial byte discarded. The next 96 chips decode to the transmitted byte 8'h3A.
- i_reset asserted for 1 cycle at chip 50 of a byte -> o_valid stays 0. A subsequent i_sof-aligned 8'h5E decodes correctly.
